vie_resp_stage: RTL
===================

VIE_RESP_STAGE -- requirements
Module: vie_resp_stage

Interface
REQ-001 SHALL have a single clock, `clock`, and a synchronous, active-high reset, `reset`.
REQ-002 Port list:
- `clock`  in  1  pipeline clock
- `reset`  in  1  synchronous, active-high reset
- `esbus_i`  in  131  from exe stage: {valid, req_sent, baddr[32], bd, cp0_addr[8], exc[6], res_from_mem, op[8], sel[2], dest[7], fixres[32], pc[32]}
- `ms_allowin`  in  1  mem stage can accept
- `flushbus_i`  in  33  {taken, target[32]}; only taken is used
- `data_data_ok`  in  1  data-side response strobe
- `data_rdata`  in  32  response data, valid with data_data_ok
- `rs_allowin`  out  1  this stage can accept
- `rsbus_o`  out  162  to mem stage: {valid, data[32], baddr, bd, cp0_addr, exc, res_from_mem, op, sel, dest, fixres, pc}
- `rsstatus_o`  out  41  forwarding: {valid, load_pending, dest[7], fixres[32]}

Function
REQ-003 SHALL hold at most one instruction, tracked by state: EMPTY, WAIT (request sent, data outstanding), READY (contents complete).
REQ-004 Accept (instruction enters this stage) SHALL occur when esbus valid, rs_allowin=1 and flush taken=0.
- Next state is WAIT if req_sent=1, else READY.
- esbus fields are registered on accept.
REQ-005 rs_allowin SHALL be 1 when the state is EMPTY, or when the state is READY and ms_allowin=1.
REQ-006 rsbus_o valid SHALL be 1 only in READY.
- Leaving READY with ms_allowin=1 and no new accept SHALL return the state to EMPTY.
REQ-007 In WAIT with data_data_ok=1 and cancel_cnt=0, data_rdata SHALL be captured into the data field and the state SHALL go to READY in the same edge.
- Minimum latency: response cycle N gives rsbus valid in cycle N+1.
REQ-008 rsbus_o data SHALL be 0 for instructions with req_sent=0.
REQ-009 A 2-bit cancel_cnt SHALL count orphaned responses.
- flush taken while in WAIT: state goes to EMPTY and cancel_cnt increments, unless data_data_ok is also 1 in that same cycle.
REQ-010 While cancel_cnt>0, each data_data_ok SHALL decrement cancel_cnt and be discarded.
- A response received in WAIT while cancel_cnt>0 SHALL NOT be captured.
REQ-011 Simultaneous flush and an orphan-consuming data_data_ok SHALL leave cancel_cnt unchanged.
- cancel_cnt SHALL saturate at 3; reaching 3 is an assertion error.
REQ-012 flush taken SHALL force the state to EMPTY from WAIT or READY and block any accept that cycle.
REQ-013 rsstatus_o SHALL carry the following fields:
- valid = (state != EMPTY)
- load_pending = (state == WAIT)
- dest = registered dest
- fixres = rsbus result: data if READY and res_from_mem, else fixres
REQ-014 SHALL accept back-to-back (one per cycle) when the state is READY and ms_allowin is held 1.

Reset
REQ-015 On reset:
- state=EMPTY, cancel_cnt=0
- rs_allowin=1, rsbus_o valid=0, rsstatus_o valid=0, load_pending=0
- Payload registers need no reset.
REQ-016 reset asserted mid-WAIT SHALL drop the instruction without counting an orphan; the response interface is reset together with this stage.

Structure
REQ-017 Bus widths (`Vesbus`=131, `Vrsbus`=162, `Vflushbus`=33, `Vrsstatus`=41) and state encodings SHALL live in the shared defines header; op codes come from the existing `VIE_OP_*` set.
REQ-018 Single module; the cancel counter SHALL be the sub-module vie_resp_cancel_cnt (inc, dec, cnt).

Verification
REQ-019 Bench SHALL cover the following directed scenarios:
- Non-memory op (pc 0xBFC00000, fixres 0x1234): rsbus valid next cycle, data=0, fixres=0x1234.
- lw with req_sent, data_ok 3 cycles later with rdata 0xDEADBEEF: load_pending=1 for 3 cycles, then READY with data=0xDEADBEEF.
- Flush during WAIT, then new lw accepted: first data_ok (0x11111111) discarded and cancel_cnt 1→0; second data_ok (0x22222222) captured.
- ms_allowin=0 for 4 cycles in READY: rsbus held stable, rs_allowin=0; released, then accepts next cycle.
- Flush and data_ok in the same WAIT cycle: state EMPTY, cancel_cnt stays 0.
- Reset asserted during WAIT: state EMPTY, cancel_cnt 0, rsbus valid 0 next cycle.

Source files
------------

// File: rtl/vie_resp_stage_pkg.sv
// Shared definitions for the response stage: bus widths, state
// encoding, registered payload layout and the forwarding helper.
package vie_resp_stage_pkg;

  localparam int Vesbus    = 131;
  localparam int Vrsbus    = 162;
  localparam int Vflushbus = 33;
  localparam int Vrsstatus = 41;
  localparam int Vpayload  = 129;

  typedef enum logic [1:0] {
    RS_EMPTY = 2'd0,
    RS_WAIT  = 2'd1,
    RS_READY = 2'd2
  } rs_state_e;

  // Mirrors esbus[128:0]: everything after valid and req_sent.
  typedef struct packed {
    logic [31:0] baddr;
    logic        bd;
    logic [7:0]  cp0_addr;
    logic [5:0]  exc;
    logic        res_from_mem;
    logic [7:0]  op;
    logic [1:0]  sel;
    logic [6:0]  dest;
    logic [31:0] fixres;
    logic [31:0] pc;
  } rs_payload_t;

  // Forwarded result: load data once it has arrived, otherwise the ALU result.
  function automatic logic [31:0] fwd_result(input logic        ready,
                                             input logic        res_from_mem,
                                             input logic [31:0] data,
                                             input logic [31:0] fixres);
    return (ready && res_from_mem) ? data : fixres;
  endfunction

endpackage

// File: rtl/vie_resp_cancel_cnt.sv
// Counts data responses still owed to instructions that were flushed
// while waiting, so those responses can be recognised and dropped.
module vie_resp_cancel_cnt
  import vie_resp_stage_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] cnt
);

  // Saturating up/down count; simultaneous inc and dec cancel out.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= 2'd0;
    end else if (inc && !dec && cnt != 2'd3) begin
      cnt <= cnt + 2'd1;
    end else if (dec && !inc && cnt != 2'd0) begin
      cnt <= cnt - 2'd1;
    end
  end

  // Three orphans in flight means the memory side is misbehaving.
  cnt_below_limit: assert property (@(posedge clock) disable iff (reset) cnt != 2'd3);

endmodule

// File: rtl/vie_resp_stage.sv
// Response stage: holds one instruction between exe and mem, waits for
// its data response when a request was sent, and drops responses that
// belong to flushed instructions.
module vie_resp_stage
  import vie_resp_stage_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [Vesbus-1:0]    esbus_i,
  input  logic                 ms_allowin,
  input  logic [Vflushbus-1:0] flushbus_i,
  input  logic                 data_data_ok,
  input  logic [31:0]          data_rdata,
  output logic                 rs_allowin,
  output logic [Vrsbus-1:0]    rsbus_o,
  output logic [Vrsstatus-1:0] rsstatus_o
);

  rs_state_e   state_q;
  rs_payload_t payload_q;
  logic [31:0] data_q;
  logic [1:0]  cancel_cnt;

  logic        es_valid;
  logic        es_req_sent;
  logic        flush;
  logic        in_wait;
  logic        in_ready;
  logic        accept;
  logic        resp_own;
  logic        cnt_inc;
  logic        cnt_dec;
  logic [31:0] unused_flush_target;

  assign es_valid            = esbus_i[130];
  assign es_req_sent         = esbus_i[129];
  assign flush               = flushbus_i[32];
  assign unused_flush_target = flushbus_i[31:0];

  assign in_wait    = (state_q == RS_WAIT);
  assign in_ready   = (state_q == RS_READY);
  assign rs_allowin = (state_q == RS_EMPTY) || (in_ready && ms_allowin);
  assign accept     = es_valid && rs_allowin && !flush;

  // A response belongs to the waiting instruction only once all orphans are gone.
  assign resp_own = in_wait && data_data_ok && (cancel_cnt == 2'd0);
  assign cnt_dec  = data_data_ok && (cancel_cnt != 2'd0);
  // Flushing a waiting instruction orphans its response unless it arrives right now.
  assign cnt_inc  = flush && in_wait && !resp_own;

  vie_resp_cancel_cnt u_cancel_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (cnt_inc),
    .dec   (cnt_dec),
    .cnt   (cancel_cnt)
  );

  // Occupancy state: flush wins, then accept, then response, then hand-off.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RS_EMPTY;
    end else if (flush) begin
      state_q <= RS_EMPTY;
    end else if (accept) begin
      state_q <= es_req_sent ? RS_WAIT : RS_READY;
    end else if (resp_own) begin
      state_q <= RS_READY;
    end else if (in_ready && ms_allowin) begin
      state_q <= RS_EMPTY;
    end
  end

  // Payload and data capture; no reset since valid is qualified by state.
  always_ff @(posedge clock) begin
    if (accept) begin
      payload_q <= rs_payload_t'(esbus_i[128:0]);
      data_q    <= 32'd0;
    end else if (resp_own) begin
      data_q    <= data_rdata;
    end
  end

  assign rsbus_o    = {in_ready, data_q, payload_q};
  assign rsstatus_o = {state_q != RS_EMPTY, in_wait, payload_q.dest,
                       fwd_result(in_ready, payload_q.res_from_mem, data_q, payload_q.fixres)};

endmodule
